// File: rtl/signedcarrynormaliser_if.sv
// Handshake bundle for signedcarrynormaliser: signed polynomial in, normalised polynomial out.
interface signedcarrynormaliser_if #(
    parameter int NUMSYMBOLS          = 16,
    parameter int INPUTSYMBOLBITWIDTH = 24,
    parameter int LOGRADIX            = 16,
    parameter int MAXPASSES           = NUMSYMBOLS
);
    localparam int PASSBITS = $clog2(MAXPASSES + 1);

    logic                                          in_valid;
    logic                                          in_ready;
    logic [NUMSYMBOLS-1:0][INPUTSYMBOLBITWIDTH-1:0] data_in;
    logic                                          out_valid;
    logic                                          out_ready;
    logic [NUMSYMBOLS:0][LOGRADIX+1:0]             data_out;
    logic [PASSBITS-1:0]                           out_passes;
    logic                                          out_overflow;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, out_passes, out_overflow
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, out_passes, out_overflow
    );
endinterface

// File: rtl/signedcarrynormaliser.sv
// Iterative signed carry normaliser: one carry-correction pass per clock until settled or out of budget.
// Optional early exit on settle is enabled by defining SIGNEDCARRYNORM_EARLYEXIT_EN.
module signedcarrynormaliser #(
    parameter int NUMSYMBOLS          = 16,
    parameter int INPUTSYMBOLBITWIDTH = 24,
    parameter int LOGRADIX            = 16,
    parameter int MAXPASSES           = NUMSYMBOLS
) (
    input  logic                   clk,
    input  logic                   reset,
    signedcarrynormaliser_if.slave bus
);
    localparam int N        = NUMSYMBOLS;
    localparam int IW       = INPUTSYMBOLBITWIDTH;
    localparam int W        = INPUTSYMBOLBITWIDTH + 1;
    localparam int LR       = LOGRADIX;
    localparam int PASSBITS = $clog2(MAXPASSES + 1);
    localparam logic [PASSBITS-1:0] PASS_LIMIT = PASSBITS'(MAXPASSES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [PASSBITS-1:0] pass_cnt;
    logic signed [W-1:0] cur   [N+1];
    logic signed [W-1:0] nxt   [N+1];
    logic signed [W-1:0] carry [1:N];
    logic                settled;
    logic                top_fits;
    logic                stop;

    // Carries are shifted into their own signed variables so the arithmetic
    // shift is never reinterpreted as logical by an unsigned add context.
    always_comb begin
        for (int i = 1; i <= N; i++) begin
            carry[i] = cur[i-1] >>> LR;
        end
        nxt[0] = $signed({{(W-LR){1'b0}}, cur[0][LR-1:0]});
        for (int i = 1; i < N; i++) begin
            nxt[i] = $signed({{(W-LR){1'b0}}, cur[i][LR-1:0]}) + carry[i];
        end
        nxt[N] = cur[N] + carry[N];
    end

    always_comb begin
        // NOTE: default first, so no path leaves settled unassigned (no latch).
        settled = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (cur[i][W-1:LR] != '0) settled = 1'b0;
        end
    end

    assign top_fits = (cur[N][W-1:LR+1] == '0) || (&cur[N][W-1:LR+1]);

`ifdef SIGNEDCARRYNORM_EARLYEXIT_EN
    assign stop = settled || (pass_cnt == PASS_LIMIT);
`else
    assign stop = (pass_cnt == PASS_LIMIT);
`endif

    assign bus.in_ready = (state == IDLE);

    // NOTE: cur is pure datapath, always loaded before it is read, so it stays out of reset.
    // NOTE: all state here uses <= so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            pass_cnt         <= '0;
            bus.out_valid    <= 1'b0;
            bus.data_out     <= '0;
            bus.out_passes   <= '0;
            bus.out_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < N; i++) begin
                            cur[i] <= {bus.data_in[i][IW-1], bus.data_in[i]};
                        end
                        cur[N]   <= '0;
                        pass_cnt <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        for (int i = 0; i <= N; i++) begin
                            bus.data_out[i] <= cur[i][LR+1:0];
                        end
                        bus.out_passes   <= pass_cnt;
                        bus.out_overflow <= !settled || !top_fits;
                        bus.out_valid    <= 1'b1;
                        state            <= DONE;
                    end else begin
                        for (int i = 0; i <= N; i++) begin
                            cur[i] <= nxt[i];
                        end
                        pass_cnt <= pass_cnt + PASSBITS'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
